// File: rtl/seg_scan_if.sv
// Host-side bundle for the 7-segment scan controller: display data handshake
// and the digit-select / BCD drive toward the external decoders.
interface seg_scan_if #(
  parameter int unsigned DIGITS = 4
);
  logic                  en;
  logic                  lz_en;
  logic                  load;
  logic [4*DIGITS-1:0]   data_in;
  logic                  load_ack;
  logic [2:0]            sel_o;
  logic [3:0]            bcd_o;
  logic                  frame_done;

  modport master (
    output en, lz_en, load, data_in,
    input  load_ack, sel_o, bcd_o, frame_done
  );

  modport slave (
    input  en, lz_en, load, data_in,
    output load_ack, sel_o, bcd_o, frame_done
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with double-buffered display data,
// per-slot blanking gap and optional leading-zero suppression.
module seg_scan_ctrl #(
  parameter int unsigned DIGITS    = 4,
  parameter int unsigned DIV       = 50000,
  parameter int unsigned BLANK_CYC = 2
) (
  input  logic      clk,
  input  logic      rst,
  seg_scan_if.slave bus
);

  localparam int unsigned CntW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned DataW = 4 * DIGITS;
  localparam logic [CntW-1:0] CntMax = CntW'(DIV - 1);
  localparam logic [2:0]      DigMax = 3'(DIGITS - 1);
  localparam logic [3:0]      Blank  = 4'hF;

  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [2:0]       dig_q, dig_d;
  logic [DataW-1:0] active_q, active_d;
  logic [DataW-1:0] shadow_q, shadow_d;
  logic             pend_q, pend_d;
  logic [2:0]       sel_q, sel_d;
  logic [3:0]       bcd_q, bcd_d;
  logic             ack_q, ack_d;
  logic             frame_done_q, frame_done_d;

  logic              eof;
  logic              xfer_ok;
  logic [DIGITS-1:0] suppress;
  logic              zero_above;
  logic [3:0]        digit_val;

  // Scan counters: slot counter and digit index, parked at zero while disabled.
  always_comb begin
    cnt_d = cnt_q;
    dig_d = dig_q;
    eof   = bus.en && (cnt_q == CntMax) && (dig_q == DigMax);
    if (!bus.en) begin
      cnt_d = '0;
      dig_d = '0;
    end else if (cnt_q == CntMax) begin
      cnt_d = '0;
      dig_d = (dig_q == DigMax) ? 3'd0 : dig_q + 3'd1;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // Active buffer only changes at a frame boundary or while the display is
  // blanked, so a refresh never mixes old and new digits.
  always_comb begin
    active_d = active_q;
    shadow_d = shadow_q;
    pend_d   = pend_q;
    ack_d    = 1'b0;
    xfer_ok  = !bus.en || eof;
    if (xfer_ok) begin
      if (bus.load) begin
        active_d = bus.data_in;
        pend_d   = 1'b0;
        ack_d    = 1'b1;
      end else if (pend_q) begin
        active_d = shadow_q;
        pend_d   = 1'b0;
        ack_d    = 1'b1;
      end
    end else if (bus.load) begin
      shadow_d = bus.data_in;
      pend_d   = 1'b1;
    end
  end

  // Leading-zero mask: a digit is dropped when it and every higher digit is zero.
  always_comb begin
    suppress   = '0;
    zero_above = 1'b1;
    for (int i = int'(DIGITS) - 1; i > 0; i--) begin
      zero_above  = zero_above && (active_q[4*i +: 4] == 4'h0);
      suppress[i] = bus.lz_en && zero_above;
    end
    digit_val = Blank;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (dig_q == 3'(i)) begin
        digit_val = suppress[i] ? Blank : active_q[4*i +: 4];
      end
    end
  end

  always_comb begin
    sel_d        = bus.en ? dig_q : 3'd0;
    bcd_d        = (!bus.en || (32'(cnt_q) < BLANK_CYC)) ? Blank : digit_val;
    frame_done_d = eof;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      dig_q        <= '0;
      active_q     <= '0;
      shadow_q     <= '0;
      pend_q       <= 1'b0;
      sel_q        <= 3'd0;
      bcd_q        <= Blank;
      ack_q        <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      dig_q        <= dig_d;
      active_q     <= active_d;
      shadow_q     <= shadow_d;
      pend_q       <= pend_d;
      sel_q        <= sel_d;
      bcd_q        <= bcd_d;
      ack_q        <= ack_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.sel_o      = sel_q;
  assign bus.bcd_o      = bcd_q;
  assign bus.load_ack   = ack_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with DIV=8, BLANK_CYC=2: frame scan order,
// load double-buffering, leading-zero suppression, disable and reset behaviour.
module tb_seg_scan_ctrl;

  localparam int unsigned Digits   = 4;
  localparam int unsigned Div      = 8;
  localparam int unsigned BlankCyc = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  seg_scan_if #(.DIGITS(Digits)) bus ();

  seg_scan_ctrl #(
    .DIGITS   (Digits),
    .DIV      (Div),
    .BLANK_CYC(BlankCyc)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one 32-cycle frame starting from scan state (cnt=0, dig=0) and checks
  // every output cycle. Loads are injected at frame positions ld1/ld2 (-1 = none).
  task automatic scan_frame(input string tag, input logic [15:0] exp,
                            input int ld1, input logic [15:0] d1,
                            input int ld2, input logic [15:0] d2,
                            input logic exp_ack);
    int slot;
    logic [3:0] eb;
    for (int j = 0; j < 32; j++) begin
      bus.load    = (j == ld1) || (j == ld2);
      bus.data_in = (j == ld2) ? d2 : d1;
      tick();
      bus.load = 1'b0;
      slot = j / 8;
      eb   = ((j % 8) < 2) ? 4'hF : exp[4*slot +: 4];
      check_eq($sformatf("%s sel j=%0d", tag, j), 32'(bus.sel_o), 32'(slot));
      check_eq($sformatf("%s bcd j=%0d", tag, j), 32'(bus.bcd_o), 32'(eb));
      check_eq($sformatf("%s frame_done j=%0d", tag, j), 32'(bus.frame_done),
               32'(j == 31));
      check_eq($sformatf("%s load_ack j=%0d", tag, j), 32'(bus.load_ack),
               32'((j == 31) && exp_ack));
    end
  endtask

  initial begin
    bus.en      = 1'b0;
    bus.lz_en   = 1'b0;
    bus.load    = 1'b0;
    bus.data_in = '0;
    rst         = 1'b1;
    repeat (3) tick();
    check_eq("reset sel", 32'(bus.sel_o), 32'd0);
    check_eq("reset bcd", 32'(bus.bcd_o), 32'hF);
    check_eq("reset ack", 32'(bus.load_ack), 32'd0);
    check_eq("reset frame_done", 32'(bus.frame_done), 32'd0);
    rst    = 1'b0;
    bus.en = 1'b1;

    scan_frame("f0", 16'h0000, 0, 16'h4321, -1, 16'h0, 1'b1);
    scan_frame("f1", 16'h4321, 5, 16'h1111, 8, 16'h2222, 1'b1);
    scan_frame("f2", 16'h2222, -1, 16'h0, -1, 16'h0, 1'b0);
    scan_frame("f3", 16'h2222, 10, 16'h9999, 31, 16'h5555, 1'b1);
    scan_frame("f4", 16'h5555, -1, 16'h0, -1, 16'h0, 1'b0);
    scan_frame("f5", 16'h5555, -1, 16'h0, 31, 16'h0070, 1'b1);
    bus.lz_en = 1'b1;
    scan_frame("f6", 16'hFF70, -1, 16'h0, 31, 16'h0000, 1'b1);
    scan_frame("f7", 16'hFFF0, -1, 16'h0, 31, 16'h0A00, 1'b1);
    scan_frame("f8", 16'hFA00, -1, 16'h0, -1, 16'h0, 1'b0);
    bus.lz_en = 1'b0;

    // Disable mid-scan, load while blanked, then re-enable.
    repeat (10) tick();
    bus.en = 1'b0;
    tick();
    check_eq("dis sel", 32'(bus.sel_o), 32'd0);
    check_eq("dis bcd", 32'(bus.bcd_o), 32'hF);
    check_eq("dis frame_done", 32'(bus.frame_done), 32'd0);
    check_eq("dis ack idle", 32'(bus.load_ack), 32'd0);
    bus.load    = 1'b1;
    bus.data_in = 16'h8888;
    tick();
    bus.load = 1'b0;
    check_eq("dis ack", 32'(bus.load_ack), 32'd1);
    check_eq("dis sel hold", 32'(bus.sel_o), 32'd0);
    check_eq("dis bcd hold", 32'(bus.bcd_o), 32'hF);
    tick();
    check_eq("dis ack single", 32'(bus.load_ack), 32'd0);
    bus.en = 1'b1;
    scan_frame("f9", 16'h8888, -1, 16'h0, -1, 16'h0, 1'b0);

    // Reset mid-frame with a pending load.
    repeat (4) tick();
    bus.load    = 1'b1;
    bus.data_in = 16'h3333;
    tick();
    bus.load = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    check_eq("mid rst sel", 32'(bus.sel_o), 32'd0);
    check_eq("mid rst bcd", 32'(bus.bcd_o), 32'hF);
    check_eq("mid rst ack", 32'(bus.load_ack), 32'd0);
    check_eq("mid rst frame_done", 32'(bus.frame_done), 32'd0);
    rst = 1'b0;
    scan_frame("f10", 16'h0000, -1, 16'h0, -1, 16'h0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Time-multiplexed scan controller for the 4-digit 7-segment display path.
- Drives the 3-line digit-select bus into the 3-to-8 active-low digit decoder, and the 4-bit BCD bus into the BCD-to-7-segment decoder.
- Blanking is done by sending code 4'hF, which the segment decoder blanks.
- Double-buffers display data so an update never lands mid-frame (no tearing); inserts a blank gap at each digit switch to suppress ghosting.

Parameters:
- DIGITS, 4, number of scanned digits (1..8); digit 0 is least significant.
- DIV, 50000, clock cycles per digit slot (>= BLANK_CYC+1).
- BLANK_CYC, 2, cycles at the start of each slot during which bcd_o = 4'hF.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous reset, active high
- en  in  1  scan enable; low = display blanked, scan parked
- lz_en  in  1  leading-zero suppression enable
- load  in  1  request to take data_in as new display value
- data_in  in  4*DIGITS  BCD digits, digit i at [4i+3:4i]
- load_ack  out  1  one-cycle pulse: load value transferred to active buffer
- sel_o  out  3  digit index to the digit-select decoder A input
- bcd_o  out  4  BCD to the segment decoder INn input
- frame_done  out  1  one-cycle pulse at end of each full scan

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst). All outputs are driven directly from flops.
- Reset values:
  - cnt=0, dig=0, active buffer=0, shadow=0, pend=0
  - sel_o=0, bcd_o=4'hF, load_ack=0, frame_done=0
- Counters:
  - cnt runs 0..DIV-1.
  - At cnt==DIV-1: cnt->0 and dig->dig+1.
  - At dig==DIGITS-1 the wrap takes dig->0 and marks end of frame (EOF).
- Outputs lag the (cnt,dig) state by exactly one cycle:
  - sel_o = previous dig.
  - bcd_o = 4'hF if previous cnt < BLANK_CYC, else the digit value (after suppression).
  - frame_done is high the cycle after the EOF state.
- Load handshake:
  - load is sampled every cycle.
  - If load=1 and not EOF: shadow<=data_in, pend<=1. A later load before EOF overwrites shadow; the newest value wins and only one ack is issued.
  - At EOF with load=1: active<=data_in directly, pend<=0.
  - At EOF with load=0 and pend=1: active<=shadow, pend<=0.
  - load_ack pulses the cycle after any transfer into active.
- Leading-zero suppression:
  - When lz_en=1, digit i>0 shows 4'hF if active digits DIGITS-1..i are all 4'h0.
  - Digit 0 is never suppressed.
  - Codes 10..15 pass through unchanged.
- en=0:
  - cnt and dig are forced to 0 and frame_done stays 0.
  - Outputs go to sel_o=0, bcd_o=4'hF.
  - Any load (or pending shadow) transfers to active immediately, with load_ack the next cycle; there is no tearing risk while blanked.
- en 0->1: scan restarts at digit 0, cnt 0, so the slot begins blanked.
- Simultaneous load and EOF: data_in wins over the older shadow.
- Reset mid-frame: all state returns to reset values on the next edge; any pending data is discarded and no ack is issued.
- dig never exceeds DIGITS-1; sel_o never exceeds DIGITS-1.

Test Plan:
- Reset, then en=1, DIV=8, BLANK_CYC=2, active=0x4321 via load:
  - After the first EOF: load_ack pulses once.
  - Each 8-cycle slot shows bcd_o=F,F then digit for 6 cycles.
  - sel_o steps 0,1,2,3,0; bcd sequence 1,2,3,4; frame_done pulses every 32 cycles.
- Load 0x1111 mid-frame, then load 0x2222 three cycles later:
  - Display unchanged until EOF.
  - Next frame shows 2,2,2,2; exactly one load_ack.
- load=1 with data 0x5555 in the EOF cycle while pend holds 0x9999:
  - Next frame shows 5s; single ack.
- lz_en=1 with active=0x0070:
  - Digits 3 and 2 show F; digit 1 shows 7; digit 0 shows 0.
  - With active=0x0000, only digit 0 shows 0.
- en=0 mid-scan:
  - Next cycle sel_o=0, bcd_o=F.
  - load 0x8888 acked the following cycle.
  - en=1: first slot is digit 0, blanked 2 cycles, then 8.
- Assert rst mid-frame with pend=1:
  - Outputs return to sel_o=0, bcd_o=F, load_ack=0.
  - After release, pending value is not shown and no ack occurs.
